// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the data memory.
// Port 0 is the CPU load/store stage, port 1 the debug/loader port. Each
// access takes IDLE -> ACCESS -> RESP (rejected accesses skip ACCESS).
// Optional build macro: DMEM_ARB_FIXED_PRI_EN gives port 0 fixed priority
// on simultaneous requests; left undefined, simultaneous requests alternate.
module dmem_arbiter #(
  parameter int MEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [31:0] RData,
  output logic        Err,
  output logic        mem_RD,
  output logic        mem_WR,
  output logic [31:0] mem_DAddr,
  output logic [31:0] mem_DataIn,
  input  logic [31:0] mem_DataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Highest legal word address, compared as a full 32-bit unsigned value.
  localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

  state_t      state;
  logic        lat_port;   // winning port of the access in flight
  logic        lat_we;     // latched direction of the access in flight

`ifndef DMEM_ARB_FIXED_PRI_EN
  logic        pri;        // 0 favours port 0, 1 favours port 1
`endif

  logic        any_req;
  logic        grant1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;

  // Pick the winner among the pending requests and check its address.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    any_req   = Req0 | Req1;
    grant1    = 1'b0;
    sel_we    = WE0;
    sel_addr  = Addr0;
    sel_wdata = WData0;
    sel_legal = 1'b0;
`ifdef DMEM_ARB_FIXED_PRI_EN
    grant1 = Req1 & ~Req0;
`else
    grant1 = Req1 & (~Req0 | pri);
`endif
    if (grant1) begin
      sel_we    = WE1;
      sel_addr  = Addr1;
      sel_wdata = WData1;
    end
    sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= MaxAddr);
  end

  // Access sequencer; all outputs are registered so the memory sees clean
  // strobes with address and data stable for the whole ACCESS cycle.
  // mem_DAddr/mem_DataIn double as the latched address and data registers:
  // they are only loaded for legal accesses, so they hold otherwise.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values and ordering between statements cannot matter.
    if (Reset) begin
      state      <= IDLE;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Err        <= 1'b0;
      RData      <= 32'h0;
      mem_RD     <= 1'b0;
      mem_WR     <= 1'b0;
      mem_DAddr  <= 32'h0;
      mem_DataIn <= 32'h0;
`ifndef DMEM_ARB_FIXED_PRI_EN
      pri        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_port <= grant1;
            lat_we   <= sel_we;
            if (sel_legal) begin
              mem_DAddr  <= sel_addr;
              mem_DataIn <= sel_wdata;
              mem_RD     <= ~sel_we;
              mem_WR     <= sel_we;
              state      <= ACCESS;
            end else begin
              // Rejected: answer immediately, never touch the memory.
              Ack0  <= ~grant1;
              Ack1  <= grant1;
              Err   <= 1'b1;
              RData <= 32'h0;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          mem_RD <= 1'b0;
          mem_WR <= 1'b0;
          RData  <= lat_we ? 32'h0 : mem_DataOut;
          Err    <= 1'b0;
          Ack0   <= ~lat_port;
          Ack1   <= lat_port;
          state  <= RESP;
        end
        RESP: begin
          Ack0  <= 1'b0;
          Ack1  <= 1'b0;
          Err   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRI_EN
          pri   <= ~lat_port;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences (reset mid-access, simultaneous requests) and random
// two-port traffic scored against a word-level memory model.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req0, Req1, WE0, WE1;
  logic [31:0] Addr0, Addr1, WData0, WData1;
  logic        Ack0, Ack1, Err, mem_RD, mem_WR;
  logic [31:0] RData, mem_DAddr, mem_DataIn, mem_DataOut;

  int n_pass  = 0;
  int n_total = 0;
  int viol    = 0;

  // Memory seen by the DUT (big-endian bytes) and the bench's reference copy.
  logic [7:0] bmem    [128];
  logic [7:0] ref_mem [128];

  dmem_arbiter #(.MEM_BYTES(128)) dut (
    .CLK(CLK), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .WE0(WE0), .WE1(WE1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Err(Err),
    .mem_RD(mem_RD), .mem_WR(mem_WR), .mem_DAddr(mem_DAddr),
    .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut)
  );

  always #5 CLK = ~CLK;

  logic [6:0] ba;
  assign ba = mem_DAddr[6:0];
  assign mem_DataOut = {bmem[ba], bmem[7'(ba + 7'd1)], bmem[7'(ba + 7'd2)], bmem[7'(ba + 7'd3)]};

  always @(posedge CLK) begin
    if (mem_WR) begin
      bmem[ba]              <= mem_DataIn[31:24];
      bmem[7'(ba + 7'd1)]   <= mem_DataIn[23:16];
      bmem[7'(ba + 7'd2)]   <= mem_DataIn[15:8];
      bmem[7'(ba + 7'd3)]   <= mem_DataIn[7:0];
    end
  end

  // Exclusivity monitor for strobes and acks.
  always @(negedge CLK) begin
    if ((mem_RD && mem_WR) || (Ack0 && Ack1)) viol <= viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic addr_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'd124);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a);
    ref_mem[i] = d[31:24]; ref_mem[i+1] = d[23:16];
    ref_mem[i+2] = d[15:8]; ref_mem[i+3] = d[7:0];
  endfunction

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin Req0 = req; WE0 = we; Addr0 = addr; WData0 = wdata; end
    else begin Req1 = req; WE1 = we; Addr1 = addr; WData1 = wdata; end
  endtask

  function automatic logic ack_of(input int port);
    return (port == 0) ? Ack0 : Ack1;
  endfunction

  // One isolated access; returns latency in cycles (-1 on timeout).
  task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err_o,
                           output logic [31:0] rdata_o, output int n_strobe,
                           output logic strobe_wr, output logic [31:0] s_addr,
                           output logic [31:0] s_data, output logic [31:0] daddr_at_ack);
    lat = -1; err_o = 1'b0; rdata_o = 32'h0; n_strobe = 0;
    strobe_wr = 1'b0; s_addr = 32'h0; s_data = 32'h0; daddr_at_ack = 32'h0;
    @(negedge CLK);
    drive(port, 1'b1, we, addr, wdata);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (mem_RD || mem_WR) begin
        n_strobe++;
        strobe_wr = mem_WR;
        s_addr    = mem_DAddr;
        s_data    = mem_DataIn;
      end
      if (ack_of(port)) begin
        lat = c; err_o = Err; rdata_o = RData; daddr_at_ack = mem_DAddr;
        break;
      end
    end
    drive(port, 1'b0, we, addr, wdata);
  endtask

  // Random requester for one port, scored against the reference memory.
  task automatic agent(input int port, input int n);
    logic        we;
    logic [31:0] addr, wdata, exp_rd;
    logic        got, legal;
    int          r;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(2, 5)) @(negedge CLK);
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      r     = $urandom_range(0, 9);
      if (r < 8)       addr = 32'($urandom_range(0, 31)) * 4;
      else if (r == 8) addr = 32'($urandom_range(0, 127)) | 32'd1;
      else             addr = $urandom | 32'h8000_0000;
      drive(port, 1'b1, we, addr, wdata);
      got = 1'b0;
      for (int c = 0; c < 30; c++) begin
        @(negedge CLK);
        if (ack_of(port)) begin got = 1'b1; break; end
      end
      check($sformatf("rnd_p%0d_ack_%0d", port, i), 32'(got), 32'd1);
      if (got) begin
        legal  = addr_legal(addr);
        exp_rd = (legal && !we) ? ref_read(addr) : 32'h0;
        check($sformatf("rnd_p%0d_err_%0d", port, i), 32'(Err), 32'(!legal));
        check($sformatf("rnd_p%0d_rdata_%0d", port, i), RData, exp_rd);
        if (legal && we) ref_write(addr, wdata);
      end
      drive(port, 1'b0, we, addr, wdata);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t        vecs [12];
    int          lat, n_strobe;
    logic        err_o, strobe_wr, saw_ack1;
    logic [31:0] rdata_o, s_addr, s_data, daddr_at_ack, last_legal;
    int          ack_port [4];
    int          ack_cyc  [4];
    int          n_ack;

    for (int i = 0; i < 128; i++) begin bmem[i] = 8'h0; ref_mem[i] = 8'h0; end
    Reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    // Reset values.
    check("rst_ctrl", {27'h0, Ack0, Ack1, Err, mem_RD, mem_WR}, 32'h0);
    check("rst_rdata", RData, 32'h0);
    check("rst_daddr", mem_DAddr, 32'h0);
    check("rst_datain", mem_DataIn, 32'h0);

    vecs[0]  = '{0, 1'b1, 32'd8,          32'h1122_3344, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'd8,          32'h0,         1'b0, 32'h1122_3344};
    vecs[2]  = '{1, 1'b0, 32'd6,          32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1, 1'b1, 32'h80,         32'hDEAD_0000, 1'b1, 32'h0};
    vecs[4]  = '{0, 1'b1, 32'd124,        32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[5]  = '{0, 1'b0, 32'd124,        32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[6]  = '{1, 1'b1, 32'd0,          32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[7]  = '{1, 1'b0, 32'd0,          32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 1'b0, 32'hFFFF_FFFC,  32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1, 1'b1, 32'd4,          32'h0102_0304, 1'b0, 32'h0};
    vecs[10] = '{0, 1'b0, 32'd4,          32'h0,         1'b0, 32'h0102_0304};
    vecs[11] = '{0, 1'b0, 32'd8,          32'h0,         1'b0, 32'h1122_3344};

    last_legal = 32'h0;
    for (int v = 0; v < 12; v++) begin
      do_access(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                lat, err_o, rdata_o, n_strobe, strobe_wr, s_addr, s_data, daddr_at_ack);
      if (!vecs[v].exp_err) last_legal = vecs[v].addr;
      check($sformatf("v%0d_latency", v), 32'(lat), vecs[v].exp_err ? 32'd1 : 32'd2);
      check($sformatf("v%0d_err", v), 32'(err_o), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_rdata", v), rdata_o, vecs[v].exp_rdata);
      check($sformatf("v%0d_strobes", v), 32'(n_strobe), vecs[v].exp_err ? 32'd0 : 32'd1);
      check($sformatf("v%0d_daddr_hold", v), daddr_at_ack, last_legal);
      if (n_strobe > 0) begin
        check($sformatf("v%0d_strobe_dir", v), 32'(strobe_wr), 32'(vecs[v].we));
        check($sformatf("v%0d_strobe_addr", v), s_addr, vecs[v].addr);
        if (vecs[v].we) check($sformatf("v%0d_strobe_data", v), s_data, vecs[v].wdata);
      end
      if (!vecs[v].exp_err && vecs[v].we) ref_write(vecs[v].addr, vecs[v].wdata);
    end

    // Reset during ACCESS of a port 1 load: no Ack, reset values next cycle.
    @(negedge CLK);
    drive(1, 1'b1, 1'b0, 32'd4, 32'h0);
    @(negedge CLK);
    check("midrst_in_access", 32'(mem_RD), 32'd1);
    Reset = 1'b1;
    drive(1, 1'b0, 1'b0, 32'd4, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
    check("midrst_ctrl", {27'h0, Ack0, Ack1, Err, mem_RD, mem_WR}, 32'h0);
    check("midrst_rdata", RData, 32'h0);
    check("midrst_daddr", mem_DAddr, 32'h0);
    check("midrst_datain", mem_DataIn, 32'h0);
    saw_ack1 = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (Ack1) saw_ack1 = 1'b1;
    end
    check("midrst_no_ack1", 32'(saw_ack1), 32'd0);

    // Simultaneous loads right after reset: grants 0,1,0,1 three cycles apart.
    drive(0, 1'b1, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd4, 32'h0);
    n_ack = 0;
    for (int c = 1; c <= 20 && n_ack < 4; c++) begin
      @(negedge CLK);
      if (Ack0 || Ack1) begin
        ack_port[n_ack] = Ack1 ? 1 : 0;
        ack_cyc[n_ack]  = c;
        check($sformatf("sim_rdata_%0d", n_ack), RData, ref_read(Ack1 ? 32'd4 : 32'd0));
        n_ack++;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'd4, 32'h0);
    check("sim_ack_count", 32'(n_ack), 32'd4);
    for (int k = 0; k < n_ack; k++) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
      check($sformatf("sim_grant_%0d", k), 32'(ack_port[k]), 32'd0);
`else
      check($sformatf("sim_grant_%0d", k), 32'(ack_port[k]), 32'(k % 2));
`endif
      if (k > 0) check($sformatf("sim_spacing_%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
    end
    repeat (3) @(negedge CLK);

    // Random traffic on both ports.
    fork
      agent(0, 1100);
      agent(1, 1100);
    join

    repeat (2) @(negedge CLK);
    check("exclusivity_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the multi-cycle CPU's byte-addressed, big-endian data memory. It sits between two requesters and the single level-sensitive RD/WR memory port:
- port 0: CPU load/store stage
- port 1: debug/loader port

It owns the memory strobes outright. It guarantees that only one requester drives an access at a time, and that the memory sees a stable address and data while a strobe is asserted.

## Interface
- MEM_BYTES, 128, data memory size in bytes; legal word addresses are 0..MEM_BYTES-4.
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0, Req1  in  1 each  access request; held high until the matching Ack.
- WE0, WE1  in  1 each  1 = store, 0 = load; held stable while Req high.
- Addr0, Addr1  in  32 each  byte address; held stable while Req high.
- WData0, WData1  in  32 each  store data; held stable while Req high.
- Ack0, Ack1  out  1 each  one-cycle completion pulse.
- RData  out  32  load data; valid in the Ack cycle; shared by both ports.
- Err  out  1  valid in the Ack cycle; 1 = access rejected.
- mem_RD, mem_WR  out  1 each  strobes to the data memory.
- mem_DAddr  out  32  address to the data memory.
- mem_DataIn  out  32  write data to the data memory.
- mem_DataOut  in  32  combinational read data from the data memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - One request: that port wins.
  - Both requests: winner chosen by the priority pointer `pri`. `pri`=0 favours port 0; `pri`=1 favours port 1.
  - On a win: latch port id, WE, Addr and WData into internal registers.
  - Legality check on the latched Addr: Addr[1:0]==0 and Addr <= MEM_BYTES-4, with a full 32-bit unsigned compare.
  - Legal: go to ACCESS. Illegal: go to RESP with err flag set, and no memory strobe is ever asserted.
- **ACCESS** (exactly one cycle)
  - mem_DAddr and mem_DataIn are driven from the latched registers.
  - mem_WR = latched WE; mem_RD = !latched WE.
  - Load: mem_DataOut is captured into RData at the end of the cycle.
  - Next state: RESP.
- **RESP** (exactly one cycle)
  - Ack of the latched port = 1; Err = err flag.
  - RData = captured load data. It is 0 for stores and for rejected accesses.
  - `pri` moves to the port that did not win.
  - Next state: IDLE.
- mem_RD and mem_WR are never high together. Both are 0 outside ACCESS.
- mem_DAddr and mem_DataIn hold their last values outside ACCESS.
- Ack0 and Ack1 are never high together.
- The non-winning request stays pending and is not lost. It is served on the next IDLE pass.
- Req deasserted before Ack is a protocol violation. The arbiter still completes the latched access and pulses Ack.

## Timing
- Reset values: Ack0=Ack1=0, Err=0, RData=0, mem_RD=mem_WR=0, mem_DAddr=0, mem_DataIn=0, state=IDLE, `pri`=0.
- Latency, legal access: request sampled at edge N; ACCESS during cycle N..N+1; Ack high during cycle N+1..N+2.
- Latency, rejected access: Ack high in the cycle after sampling, one cycle earlier than a legal access.
- Throughput: one access per 3 cycles. After RESP, the FSM re-arbitrates in IDLE.
- A Req still high in the cycle after Ack is treated as a new request.
- Both requests continuously high: grants alternate 0,1,0,1...
- Reset asserted in any state: at the next edge, return to reset values. Any in-flight access is abandoned with no Ack. A store in ACCESS may already have been written.

## Configuration
- DMEM_ARB_FIXED_PRI_EN defined: port 0 always wins simultaneous requests. `pri` is not implemented and port 1 may starve.
- DMEM_ARB_FIXED_PRI_EN undefined (default): round-robin via `pri`, as described in Operation.

## Test plan
- **Port 0 store then load:** Req0 store Addr0=8, WData0=0x11223344, then Req0 load Addr0=8.
  - Store: mem_WR high for exactly 1 cycle with mem_DAddr=8.
  - Load: Ack0 with RData=0x11223344, Err=0.
- **Simultaneous requests after reset:** Req0 and Req1 both high, loads from 0 and 4.
  - Grant order 0,1,0,1 (round-robin). Each Ack 3 cycles apart.
  - With DMEM_ARB_FIXED_PRI_EN defined: only Ack0 while Req0 is held.
- **Illegal addresses:** Addr1=6 (misaligned), then Addr1=0x80 with MEM_BYTES=128 (out of range).
  - Ack1 with Err=1 and RData=0, one cycle after sampling.
  - mem_RD and mem_WR stay 0 throughout.
- **Reset mid-access:** Reset pulsed during ACCESS of a Req1 load.
  - No Ack1. All outputs at reset values the next cycle. `pri`=0.
- **Boundary address:** Addr0=124 (MEM_BYTES=128) store 0xA5A5A5A5, then load.
  - Err=0. Load returns 0xA5A5A5A5.
- **Strobe invariant:** random traffic on both ports for 10k cycles.
  - mem_RD & mem_WR is never 1; Ack0 & Ack1 is never 1.
  - Every Req eventually receives an Ack (round-robin build).
